ota_bitstream_decoder: RTL and testbench
========================================

# ota_bitstream_decoder

Receive-side companion to the gate-level digital OTA/comparator cell: it consumes the OTA's 1-bit output stream and decodes it into a multibit density value. The decoder runs an accumulate-and-dump (first-order CIC) over a fixed window of samples and presents each result through a valid/ack hold register, with overrun and saturation flags. It sits in the Tiny Tapeout top wrapper between the OTA output net and the uo_out/uio pins; pin mapping belongs to the wrapper, not to this block.

## Interface
- WINDOW_LOG2, default 8: window length = 2^WINDOW_LOG2 samples; result width = WINDOW_LOG2 bits.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level; high = decode enabled, low = idle/flush.
- sample_en  in  1  per-cycle sample strobe (tie high to sample every clock).
- bit_in  in  1  raw OTA output, asynchronous to clk.
- ack  in  1  consumer acknowledges the held result.
- result  out  WINDOW_LOG2  last decoded count of ones in a window, saturated.
- valid  out  1  result held and not yet acknowledged.
- sat  out  1  last result was saturated (all 2^N samples were 1).
- overrun  out  1  sticky: a result was overwritten while unacknowledged.
- busy  out  1  state != IDLE.

## Operation
- bit_in passes through a 2-flop synchronizer (reset 0) and produces s2; only s2 is accumulated.
- FSM states: IDLE, SETTLE, RUN.
  - IDLE: phase = 0, acc = 0. When start = 1 on an edge, transition to SETTLE.
  - SETTLE: phase counts sample_en edges; acc is not loaded into result. When phase = 2^N-1 and sample_en = 1, transition to RUN with phase = 0 and acc = 0. This discards the first window, which contains synchronizer and OTA start-up samples.
  - RUN: on each sample_en edge, acc <= acc + s2 and phase <= phase + 1. At the wrap edge (phase = 2^N-1):
    - result <= min(acc + s2, 2^N-1)
    - sat <= (acc + s2 == 2^N)
    - valid <= 1
    - acc <= 0, phase <= 0
  - start = 0 in any state: IDLE on the next edge; phase and acc are cleared. result, valid, and sat are preserved.
- Width rules: acc is WINDOW_LOG2+1 bits and never wraps. result saturates; it does not truncate.
- Handshake:
  - An edge with valid & ack clears valid.
  - A new result on the same edge as ack takes priority: valid stays 1 and overrun is not set.
  - A new result while valid = 1 and ack = 0 overwrites result and sets overrun. overrun is cleared only by rst.
- sample_en = 0 freezes phase and acc. FSM exit on start = 0 still takes effect.

## Timing
- Reset values: result = 0, valid = 0, sat = 0, overrun = 0, busy = 0, state = IDLE, sync flops = 0, phase = 0, acc = 0.
- rst asserted mid-window behaves like reset: the partial window is dropped.
- bit_in to s2 latency is 2 cycles. A sample counted at edge k is bit_in as registered at edge k-2.
- With sample_en tied to 1, valid first rises 2·2^N edges after the edge that samples start = 1. After that, valid rises every 2^N edges.
- result, valid, and sat update on the same edge. ack takes effect on the edge that samples it. valid clears one cycle after ack is presented.
- busy is registered from state and tracks the FSM with zero added latency.

## Structure
- Package ota_dec_pkg holds:
  - the state enum: IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2
  - the default WINDOW_LOG2 constant
- Sub-module ota_sync2: the 2-flop synchronizer with synchronous active-high reset, reused for any other async OTA nets.
- Top-level decoder holds the FSM, phase counter, accumulator, and result/handshake registers.

## Test plan
All scenarios use WINDOW_LOG2 = 4, sample_en = 1.
- Reset then idle: hold rst for 2 cycles, start = 0, toggle bit_in → all outputs stay 0; busy = 0.
- Alternating bit_in (1,0,1,0…), start = 1 → valid rises 32 edges after start is sampled; result = 8, sat = 0. Repeats every 16 edges.
- bit_in held at 1 → result = 15, sat = 1. bit_in held at 0 → result = 0, sat = 0.
- ack never asserted across 2 windows → second result overwrites the first; overrun = 1 and stays 1 until rst. ack on the same edge as a new result → valid stays 1, overrun stays 0.
- start dropped at phase 7 of RUN, raised again 3 cycles later → no result from the partial window; the next valid comes 32 edges after the restart; the held result is unchanged meanwhile.
- rst pulsed mid-RUN while valid = 1 → result = 0, valid = 0, overrun = 0, state = IDLE on the next edge.

Source files
------------

// File: rtl/ota_dec_pkg.sv
// Shared types and defaults for the OTA bitstream decoder.
// Holds the decoder FSM encoding and the default window size.
package ota_dec_pkg;

  localparam int WINDOW_LOG2_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_e;

endpackage : ota_dec_pkg

// File: rtl/ota_sync2.sv
// Two-flop synchronizer for nets arriving asynchronously from the OTA cell.
// Synchronous active-high reset clears both stages.
module ota_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule : ota_sync2

// File: rtl/ota_bitstream_decoder.sv
// Accumulate-and-dump decoder turning the OTA 1-bit stream into a density
// count per 2^WINDOW_LOG2-sample window, with a valid/ack hold register.
module ota_bitstream_decoder
  import ota_dec_pkg::*;
#(
  parameter int WINDOW_LOG2 = WINDOW_LOG2_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sample_en,
  input  logic                   bit_in,
  input  logic                   ack,
  output logic [WINDOW_LOG2-1:0] result,
  output logic                   valid,
  output logic                   sat,
  output logic                   overrun,
  output logic                   busy
);

  localparam int N = WINDOW_LOG2;
  localparam logic [N-1:0] PHASE_LAST = '1;
  localparam logic [N-1:0] RESULT_MAX = '1;
  localparam logic [N:0]   ACC_FULL   = {1'b1, {N{1'b0}}};

  state_e         state_q, state_d;
  logic [N-1:0]   phase_q, phase_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   result_q, result_d;
  logic           valid_q, valid_d;
  logic           sat_q, sat_d;
  logic           overrun_q, overrun_d;
  logic           busy_q, busy_d;

  logic           s2;
  logic [N:0]     acc_sum;
  logic           dump;

  ota_sync2 #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bit_in),
    .q   (s2)
  );

  // One extra bit of headroom so a full window of ones (2^N) never wraps.
  assign acc_sum = acc_q + {{N{1'b0}}, s2};

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    result_d  = result_q;
    valid_d   = valid_q;
    sat_d     = sat_q;
    overrun_d = overrun_q;
    dump      = 1'b0;

    if (valid_q && ack) valid_d = 1'b0;

    if (!start) begin
      state_d = IDLE;
      phase_d = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          phase_d = '0;
          acc_d   = '0;
        end
        // First window is thrown away: it holds synchronizer/OTA start-up junk.
        SETTLE: begin
          if (sample_en) begin
            if (phase_q == PHASE_LAST) begin
              state_d = RUN;
              phase_d = '0;
              acc_d   = '0;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (sample_en) begin
            if (phase_q == PHASE_LAST) begin
              dump    = 1'b1;
              phase_d = '0;
              acc_d   = '0;
            end else begin
              phase_d = phase_q + 1'b1;
              acc_d   = acc_sum;
            end
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
          acc_d   = '0;
        end
      endcase
    end

    // A fresh result wins over a same-edge ack; overrun only without ack.
    if (dump) begin
      result_d = (acc_sum == ACC_FULL) ? RESULT_MAX : acc_sum[N-1:0];
      sat_d    = (acc_sum == ACC_FULL);
      valid_d  = 1'b1;
      if (valid_q && !ack) overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign result  = result_q;
  assign valid   = valid_q;
  assign sat     = sat_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule : ota_bitstream_decoder

// File: tb/tb_ota_bitstream_decoder.sv
// Directed self-checking bench for ota_bitstream_decoder with a 16-sample window.
module tb_ota_bitstream_decoder;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sample_en = 1'b1;
  logic         bit_in = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] result;
  logic         valid;
  logic         sat;
  logic         overrun;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int mode  = 0;  // 0: bit_in low, 1: bit_in high, 2: alternate every cycle

  ota_bitstream_decoder #(.WINDOW_LOG2(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample_en (sample_en),
    .bit_in    (bit_in),
    .ack       (ack),
    .result    (result),
    .valid     (valid),
    .sat       (sat),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (mode == 2) bit_in = ~bit_in;
    else           bit_in = (mode == 1);
  endtask

  task automatic set_mode(input int m);
    mode   = m;
    bit_in = (m == 1);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; sample_en = 1'b1;
    set_mode(2);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst = 1'b0;
      step();
      tests++;
      if ({result, valid, sat, overrun, busy} !== '0) begin
        $display("FAIL reset_idle[%0d]: got result=%0d valid=%b sat=%b overrun=%b busy=%b, expected all 0",
                 i, result, valid, sat, overrun, busy);
        fails++;
      end
    end
  endtask

  task automatic test_alternating();
    int n;
    set_mode(2);
    start = 1'b1;
    wait_valid(64, n);
    tests++; if (n !== 33) begin $display("FAIL first_valid_latency: got step %0d, expected 33", n); fails++; end
    tests++; if (result !== 4'd8) begin $display("FAIL alt_result: got %0d, expected 8", result); fails++; end
    tests++; if (sat !== 1'b0) begin $display("FAIL alt_sat: got %b, expected 0", sat); fails++; end
    tests++; if (overrun !== 1'b0) begin $display("FAIL alt_overrun: got %b, expected 0", overrun); fails++; end
    tests++; if (busy !== 1'b1) begin $display("FAIL alt_busy: got %b, expected 1", busy); fails++; end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests++; if (valid !== 1'b0) begin $display("FAIL ack_clears_valid: got %b, expected 0", valid); fails++; end
    wait_valid(32, n);
    tests++; if (n !== 15) begin $display("FAIL window_period: got step %0d, expected 15", n); fails++; end
    tests++; if (result !== 4'd8) begin $display("FAIL alt_result_repeat: got %0d, expected 8", result); fails++; end
  endtask

  task automatic test_constant();
    int n;
    ack = 1'b1; start = 1'b0;
    set_mode(1);
    step();
    ack = 1'b0;
    tests++; if (busy !== 1'b0) begin $display("FAIL stop_busy: got %b, expected 0", busy); fails++; end
    tests++; if (valid !== 1'b0) begin $display("FAIL stop_valid: got %b, expected 0", valid); fails++; end
    tests++; if (result !== 4'd8) begin $display("FAIL stop_result_held: got %0d, expected 8", result); fails++; end
    start = 1'b1;
    wait_valid(64, n);
    tests++; if (n !== 33) begin $display("FAIL ones_latency: got step %0d, expected 33", n); fails++; end
    tests++; if (result !== 4'd15) begin $display("FAIL ones_result: got %0d, expected 15", result); fails++; end
    tests++; if (sat !== 1'b1) begin $display("FAIL ones_sat: got %b, expected 1", sat); fails++; end
    ack = 1'b1; start = 1'b0;
    set_mode(0);
    step();
    ack = 1'b0; start = 1'b1;
    wait_valid(64, n);
    tests++; if (n !== 33) begin $display("FAIL zeros_latency: got step %0d, expected 33", n); fails++; end
    tests++; if (result !== 4'd0) begin $display("FAIL zeros_result: got %0d, expected 0", result); fails++; end
    tests++; if (sat !== 1'b0) begin $display("FAIL zeros_sat: got %b, expected 0", sat); fails++; end
  endtask

  task automatic test_overrun();
    // bit_in rises right after the wrap edge; the 2-cycle synchronizer
    // latency means the first two samples of this window are still 0.
    set_mode(1);
    repeat (15) step();
    tests++; if (result !== 4'd0 || overrun !== 1'b0 || valid !== 1'b1) begin
      $display("FAIL pre_overwrite: got result=%0d overrun=%b valid=%b, expected 0/0/1", result, overrun, valid); fails++;
    end
    step();
    tests++; if (result !== 4'd14) begin $display("FAIL overwrite_result: got %0d, expected 14", result); fails++; end
    tests++; if (overrun !== 1'b1) begin $display("FAIL overrun_set: got %b, expected 1", overrun); fails++; end
    tests++; if (sat !== 1'b0) begin $display("FAIL overwrite_sat: got %b, expected 0", sat); fails++; end
    repeat (16) step();
    tests++; if (result !== 4'd15 || sat !== 1'b1) begin
      $display("FAIL second_overwrite: got result=%0d sat=%b, expected 15/1", result, sat); fails++;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests++; if (valid !== 1'b0) begin $display("FAIL overrun_ack_valid: got %b, expected 0", valid); fails++; end
    tests++; if (overrun !== 1'b1) begin $display("FAIL overrun_sticky: got %b, expected 1", overrun); fails++; end
  endtask

  task automatic test_ack_same_edge();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (overrun !== 1'b0) begin $display("FAIL rst_clears_overrun: got %b, expected 0", overrun); fails++; end
    set_mode(2);
    wait_valid(64, n);
    tests++; if (n !== 33) begin $display("FAIL post_rst_latency: got step %0d, expected 33", n); fails++; end
    repeat (15) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests++; if (valid !== 1'b1) begin $display("FAIL ack_same_edge_valid: got %b, expected 1", valid); fails++; end
    tests++; if (overrun !== 1'b0) begin $display("FAIL ack_same_edge_overrun: got %b, expected 0", overrun); fails++; end
    tests++; if (result !== 4'd8) begin $display("FAIL ack_same_edge_result: got %0d, expected 8", result); fails++; end
  endtask

  task automatic test_restart();
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (6) step();
    tests++; if (valid !== 1'b0) begin $display("FAIL restart_pre_valid: got %b, expected 0", valid); fails++; end
    start = 1'b0;
    set_mode(1);
    step();
    tests++; if (busy !== 1'b0 || result !== 4'd8) begin
      $display("FAIL restart_idle: got busy=%b result=%0d, expected 0/8", busy, result); fails++;
    end
    repeat (2) step();
    start = 1'b1;
    repeat (32) step();
    tests++; if (valid !== 1'b0 || result !== 4'd8) begin
      $display("FAIL restart_held: got valid=%b result=%0d, expected 0/8", valid, result); fails++;
    end
    step();
    tests++; if (valid !== 1'b1 || result !== 4'd15 || sat !== 1'b1) begin
      $display("FAIL restart_result: got valid=%b result=%0d sat=%b, expected 1/15/1", valid, result, sat); fails++;
    end
  endtask

  task automatic test_rst_mid_run();
    repeat (16) step();
    tests++; if (overrun !== 1'b1 || valid !== 1'b1) begin
      $display("FAIL mid_run_pre: got overrun=%b valid=%b, expected 1/1", overrun, valid); fails++;
    end
    repeat (5) step();
    rst = 1'b1;
    step();
    tests++; if ({result, valid, sat, overrun, busy} !== '0) begin
      $display("FAIL mid_run_rst: got result=%0d valid=%b sat=%b overrun=%b busy=%b, expected all 0",
               result, valid, sat, overrun, busy); fails++;
    end
    rst = 1'b0;
    step();
    tests++; if (busy !== 1'b1 || valid !== 1'b0) begin
      $display("FAIL mid_run_restart: got busy=%b valid=%b, expected 1/0", busy, valid); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_constant();
    test_overrun();
    test_ack_same_edge();
    test_restart();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ota_bitstream_decoder
